// File: rtl/ps2_keypad_pkg.sv
// ps2_keypad_pkg: shared types and helpers for the PS/2 -> CHIP-8 keypad block.
//   state_t    parser FSM states (IDLE, EXT, BRK, EXT_BRK)
//   SC_EXT     Set-2 extended prefix byte (E0)
//   SC_BRK     Set-2 break prefix byte (F0)
//   key_map_t  {valid, key} result of a scancode lookup
//   map_base   plain scancode -> hex key
//   map_arrow  extended (E0-prefixed) arrow scancode -> hex key
package ps2_keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef struct packed {
        logic       valid;
        logic [3:0] key;
    } key_map_t;

    // Left-hand 4x4 block of a QWERTY keyboard laid over the CHIP-8 pad.
    function automatic key_map_t map_base(input logic [7:0] sc);
        key_map_t m;
        m.valid = 1'b1;
        m.key   = '0;
        case (sc)
            8'h16: m.key = 4'h1;
            8'h1E: m.key = 4'h2;
            8'h26: m.key = 4'h3;
            8'h25: m.key = 4'hC;
            8'h15: m.key = 4'h4;
            8'h1D: m.key = 4'h5;
            8'h24: m.key = 4'h6;
            8'h2D: m.key = 4'hD;
            8'h1C: m.key = 4'h7;
            8'h1B: m.key = 4'h8;
            8'h23: m.key = 4'h9;
            8'h2B: m.key = 4'hE;
            8'h1A: m.key = 4'hA;
            8'h22: m.key = 4'h0;
            8'h21: m.key = 4'hB;
            8'h2A: m.key = 4'hF;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

    // Arrow keys: up/left/right/down onto the usual CHIP-8 direction keys.
    function automatic key_map_t map_arrow(input logic [7:0] sc);
        key_map_t m;
        m.valid = 1'b1;
        m.key   = '0;
        case (sc)
            8'h75: m.key = 4'h2;
            8'h6B: m.key = 4'h4;
            8'h74: m.key = 4'h6;
            8'h72: m.key = 4'h8;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_keypad_sync_edge.sv
// ps2_sync_edge: two-flop synchronizer plus an edge register, producing a
// one-cycle pulse in the clk domain on each rising edge of an async input.
//   clk   in  system clock
//   res   in  synchronous active-high reset
//   din   in  asynchronous level input
//   rise  out one-cycle pulse, s2 & ~s3
module ps2_sync_edge (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (res) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/ps2_keypad.sv
// ps2_keypad: turns the PS/2 decoder byte stream (ps2_clk domain) into the
// 16-key CHIP-8 hex keypad state in the clk domain.
//   TIMEOUT_CYCLES  clk cycles a prefix state may persist (min 4)
//   clk, res        system clock, synchronous active-high reset
//   ps2_ready       decoder byte strobe (async); ps2_data stable while high
//   ps2_error       decoder error strobe (async)
//   ps2_data[7:0]   decoder byte
//   keys[15:0]      bit n set while CHIP-8 key n is held
//   any_key         registered OR of keys (one cycle behind keys)
//   key_event       one-cycle pulse per mapped make/break
//   key_code[3:0]   key of the last event
//   key_down        1 = make, 0 = break, for the last event
// Build option: define PS2_KEYPAD_ARROWS_EN to map the E0-prefixed arrow
// keys onto keys 2/4/6/8; otherwise extended terminal bytes are consumed
// silently.
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ps2_ready,
    input  logic        ps2_error,
    input  logic [7:0]  ps2_data,
    output logic [15:0] keys,
    output logic        any_key,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_down
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          ready_rise;
    logic          error_rise;
    logic [7:0]    byte_q;
    logic          byte_valid;
    state_t        state;
    state_t        nxt;
    key_map_t      hit;
    logic          hit_down;
    logic [CW-1:0] cnt;
    logic          timeout;

    ps2_sync_edge u_sync_ready (
        .clk  (clk),
        .res  (res),
        .din  (ps2_ready),
        .rise (ready_rise)
    );

    ps2_sync_edge u_sync_error (
        .clk  (clk),
        .res  (res),
        .din  (ps2_error),
        .rise (error_rise)
    );

    assign timeout = (state != IDLE) && (cnt == TO_LAST);

    // Parse of the captured byte against the current prefix state.
    always_comb begin
        nxt      = IDLE;
        hit      = '0;
        hit_down = 1'b0;
        case (state)
            IDLE: begin
                if (byte_q == SC_EXT) begin
                    nxt = EXT;
                end else if (byte_q == SC_BRK) begin
                    nxt = BRK;
                end else begin
                    hit      = map_base(byte_q);
                    hit_down = 1'b1;
                end
            end
            EXT: begin
                if (byte_q == SC_BRK) begin
                    nxt = EXT_BRK;
                end else if (byte_q == SC_EXT) begin
                    nxt = EXT;
                end else begin
`ifdef PS2_KEYPAD_ARROWS_EN
                    hit = map_arrow(byte_q);
`else
                    hit = '0;
`endif
                    hit_down = 1'b1;
                end
            end
            BRK: begin
                hit      = map_base(byte_q);
                hit_down = 1'b0;
            end
            EXT_BRK: begin
`ifdef PS2_KEYPAD_ARROWS_EN
                hit = map_arrow(byte_q);
`else
                hit = '0;
`endif
                hit_down = 1'b0;
            end
            default: nxt = IDLE;
        endcase
    end

    // Priority: error rise drops both the pending and the incoming byte;
    // a timeout drops only the pending byte (an incoming one is still
    // captured and parsed from IDLE next cycle).
    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            cnt        <= '0;
            byte_q     <= '0;
            byte_valid <= 1'b0;
            keys       <= '0;
            any_key    <= 1'b0;
            key_event  <= 1'b0;
            key_code   <= '0;
            key_down   <= 1'b0;
        end else begin
            key_event <= 1'b0;
            any_key   <= |keys;
            if (error_rise) begin
                state      <= IDLE;
                cnt        <= '0;
                byte_valid <= 1'b0;
            end else begin
                byte_valid <= ready_rise;
                if (ready_rise) begin
                    byte_q <= ps2_data;
                end
                if (state == IDLE || ready_rise || byte_valid || timeout) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (timeout) begin
                    state <= IDLE;
                end else if (byte_valid) begin
                    state <= nxt;
                    if (hit.valid) begin
                        keys[hit.key] <= hit_down;
                        key_event     <= 1'b1;
                        key_code      <= hit.key;
                        key_down      <= hit_down;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keypad.sv
// tb_ps2_keypad: self-checking bench for ps2_keypad. A directed vector table
// plus hand-written corner sequences, followed by random byte traffic
// checked against a prefix-queue reference model of the Set-2 parser.
module tb_ps2_keypad;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        ps2_ready = 1'b0;
    logic        ps2_error = 1'b0;
    logic [7:0]  ps2_data = 8'h00;
    logic [15:0] keys;
    logic        any_key;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_down;

    int total = 0;
    int bad   = 0;

    ps2_keypad #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .res       (res),
        .ps2_ready (ps2_ready),
        .ps2_error (ps2_error),
        .ps2_data  (ps2_data),
        .keys      (keys),
        .any_key   (any_key),
        .key_event (key_event),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  base_sc [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                                  8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
    logic [7:0]  prefix [$];
    logic [15:0] mkeys  = '0;
    logic [3:0]  mcode  = '0;
    logic        mdown  = 1'b0;

    function automatic int find_key(input logic [7:0] b, input logic ext);
        if (!ext) begin
            for (int i = 0; i < 16; i++)
                if (base_sc[i] == b) return i;
            return -1;
        end
`ifdef PS2_KEYPAD_ARROWS_EN
        case (b)
            8'h75: return 2;
            8'h6B: return 4;
            8'h74: return 6;
            8'h72: return 8;
            default: return -1;
        endcase
`else
        return -1;
`endif
    endfunction

    task automatic model_byte(input logic [7:0] b, output logic ev);
        int   idx;
        logic ext;
        logic brk;
        ev = 1'b0;
        if (prefix.size() == 0 && (b == 8'hE0 || b == 8'hF0)) begin
            prefix.push_back(b);
            return;
        end
        if (prefix.size() == 1 && prefix[0] == 8'hE0 && b == 8'hE0) return;
        if (prefix.size() == 1 && prefix[0] == 8'hE0 && b == 8'hF0) begin
            prefix.push_back(b);
            return;
        end
        ext = (prefix.size() > 0) && (prefix[0] == 8'hE0);
        brk = (prefix.size() > 0) && (prefix[prefix.size()-1] == 8'hF0);
        prefix.delete();
        idx = find_key(b, ext);
        if (idx >= 0) begin
            mkeys[idx] = !brk;
            mcode      = 4'(idx);
            mdown      = !brk;
            ev         = 1'b1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Sends one byte, checks event timing (nothing at edge 3, result at
    // edge 4, any_key at edge 5) against the model, returns sampled outputs.
    task automatic send(input logic [7:0] b, output logic ev, output logic [15:0] k,
                        output logic [3:0] c, output logic d);
        logic m_ev;
        model_byte(b, m_ev);
        @(negedge clk);
        ps2_data  = b;
        ps2_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("early_event", 32'(key_event), 32'(0));
        @(posedge clk);
        #1;
        ev = key_event; k = keys; c = key_code; d = key_down;
        chk("m_event", 32'(key_event), 32'(m_ev));
        chk("m_keys", 32'(keys), 32'(mkeys));
        chk("m_code", 32'(key_code), 32'(mcode));
        chk("m_down", 32'(key_down), 32'(mdown));
        @(posedge clk);
        #1;
        chk("m_any_key", 32'(any_key), 32'(|mkeys));
        chk("event_pulse", 32'(key_event), 32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        ps2_ready = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_q(input logic [7:0] b);
        logic ev; logic [15:0] k; logic [3:0] c; logic d;
        send(b, ev, k, c, d);
    endtask

    task automatic error_pulse();
        @(negedge clk);
        ps2_error = 1'b1;
        repeat (6) @(negedge clk);
        ps2_error = 1'b0;
        repeat (6) @(negedge clk);
        prefix.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_keys", 32'(keys), 32'(0));
        chk("rst_any", 32'(any_key), 32'(0));
        chk("rst_event", 32'(key_event), 32'(0));
        chk("rst_code", 32'(key_code), 32'(0));
        chk("rst_down", 32'(key_down), 32'(0));
        @(negedge clk);
        res = 1'b0;
        prefix.delete();
        mkeys = '0; mcode = '0; mdown = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0]  b;
        logic        ev;
        logic [3:0]  code;
        logic        down;
        logic [15:0] k;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input logic [7:0] b, input logic ev, input logic [3:0] code,
                                input logic down, input logic [15:0] k);
        vec_t v;
        v.b = b; v.ev = ev; v.code = code; v.down = down; v.k = k;
        tbl.push_back(v);
    endfunction

    initial begin
        logic        ev;
        logic [15:0] k;
        logic [3:0]  c;
        logic        d;
        int          sel;
        logic [7:0]  rb;
        logic [7:0]  pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'hFA, 8'hAA, 8'hE1, 8'h00};

        add(8'h1D, 1, 4'h5, 1, 16'h0020);
        add(8'hF0, 0, 4'h0, 0, 16'h0020);
        add(8'h1D, 1, 4'h5, 0, 16'h0000);
        add(8'h16, 1, 4'h1, 1, 16'h0002);
        add(8'h2A, 1, 4'hF, 1, 16'h8002);
        add(8'hF0, 0, 4'h0, 0, 16'h8002);
        add(8'h16, 1, 4'h1, 0, 16'h8000);
        add(8'h24, 1, 4'h6, 1, 16'h8040);
        add(8'h24, 1, 4'h6, 1, 16'h8040);
        add(8'hFA, 0, 4'h0, 0, 16'h8040);
        add(8'hAA, 0, 4'h0, 0, 16'h8040);
        add(8'hE1, 0, 4'h0, 0, 16'h8040);
        add(8'h75, 0, 4'h0, 0, 16'h8040);
        add(8'hE0, 0, 4'h0, 0, 16'h8040);
`ifdef PS2_KEYPAD_ARROWS_EN
        add(8'h75, 1, 4'h2, 1, 16'h8044);
        add(8'hE0, 0, 4'h0, 0, 16'h8044);
        add(8'hF0, 0, 4'h0, 0, 16'h8044);
        add(8'h75, 1, 4'h2, 0, 16'h8040);
`else
        add(8'h75, 0, 4'h0, 0, 16'h8040);
        add(8'hE0, 0, 4'h0, 0, 16'h8040);
        add(8'hF0, 0, 4'h0, 0, 16'h8040);
        add(8'h75, 0, 4'h0, 0, 16'h8040);
`endif

        repeat (3) @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            send(tbl[i].b, ev, k, c, d);
            chk("v_event", 32'(ev), 32'(tbl[i].ev));
            chk("v_keys", 32'(k), 32'(tbl[i].k));
            if (tbl[i].ev) begin
                chk("v_code", 32'(c), 32'(tbl[i].code));
                chk("v_down", 32'(d), 32'(tbl[i].down));
            end
        end

        // Error mid-prefix: F0 is abandoned, 1C becomes a make of key 7.
        do_reset();
        send_q(8'hF0);
        error_pulse();
        send(8'h1C, ev, k, c, d);
        chk("err_event", 32'(ev), 32'(1));
        chk("err_down", 32'(d), 32'(1));
        chk("err_keys", 32'(k), 32'(16'h0080));

        // Timeout: stale F0 abandoned, 15 is a make of key 4.
        send_q(8'hF0);
        repeat (TO + 10) @(negedge clk);
        prefix.delete();
        send(8'h15, ev, k, c, d);
        chk("to_code", 32'(c), 32'(4));
        chk("to_down", 32'(d), 32'(1));
        chk("to_keys", 32'(k), 32'(16'h0090));

        // Reset mid-prefix, then 1C parses from IDLE.
        send_q(8'hF0);
        do_reset();
        send(8'h1C, ev, k, c, d);
        chk("rmp_down", 32'(d), 32'(1));
        chk("rmp_keys", 32'(k), 32'(16'h0080));

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 4) begin
                error_pulse();
            end else if (sel < 7) begin
                repeat (TO + 20) @(negedge clk);
                prefix.delete();
            end else if (sel < 9) begin
                do_reset();
            end else begin
                if (sel < 60) rb = base_sc[$urandom_range(0, 15)];
                else rb = pool[$urandom_range(0, 7)];
                send_q(rb);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
